// File: rtl/accum_bank_pkg.sv
// Shared mode constants and saturation-bound helpers for the accumulator bank.
package accum_bank_pkg;

  // Arithmetic interpretation of the accumulator contents.
  localparam int SIGN_UNSIGNED = 0;
  localparam int SIGN_TWOS     = 1;

  // Behaviour when a result falls outside the representable range.
  localparam int OVF_WRAP = 0;
  localparam int OVF_SAT  = 1;

  // Widest accumulator the bound helpers can describe.
  localparam int BOUND_W = 64;

  // Largest representable value for a w-bit word, returned zero-extended
  // to BOUND_W bits; callers keep the low w bits.
  function automatic logic [BOUND_W-1:0] sat_max(input int w, input int sign_mode);
    logic [BOUND_W-1:0] r;
    r = '0;
    for (int i = 0; i < BOUND_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    if (sign_mode == SIGN_TWOS && w > 0) r[w-1] = 1'b0;
    return r;
  endfunction

  // Smallest representable value for a w-bit word, as a sign-extended
  // BOUND_W-bit pattern; callers keep the low w bits.
  function automatic logic [BOUND_W-1:0] sat_min(input int w, input int sign_mode);
    logic [BOUND_W-1:0] r;
    r = '0;
    for (int i = 0; i < BOUND_W; i++) begin
      if (sign_mode == SIGN_TWOS && i >= w - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_sat.sv
// Combinational add/subtract with overflow detection and clamp-or-wrap result.
module accum_sat
  import accum_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SIGN       = 0,
  parameter int OVERFLOW   = 1
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  sub_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  ovf_o
);

  localparam logic [BOUND_W-1:0] MAX_FULL = sat_max(DATA_WIDTH, SIGN);
  localparam logic [BOUND_W-1:0] MIN_FULL = sat_min(DATA_WIDTH, SIGN);
  localparam logic [DATA_WIDTH-1:0] MAX_V = MAX_FULL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] MIN_V = MIN_FULL[DATA_WIDTH-1:0];

  // One extra bit holds the exact result of any single add or subtract.
  logic [DATA_WIDTH:0] a_x;
  logic [DATA_WIDTH:0] b_x;
  logic [DATA_WIDTH:0] sum_x;
  logic                ovf;

  // Extend operands, form the exact result, flag out-of-range, pick output.
  always_comb begin
    a_x      = {1'b0, a_i};
    b_x      = {1'b0, b_i};
    sum_x    = '0;
    ovf      = 1'b0;
    result_o = '0;
    if (SIGN == SIGN_TWOS) begin
      a_x = {a_i[DATA_WIDTH-1], a_i};
      b_x = {b_i[DATA_WIDTH-1], b_i};
    end
    sum_x = sub_i ? (a_x - b_x) : (a_x + b_x);
    if (SIGN == SIGN_TWOS) begin
      // Exact sign and truncated sign disagree only when out of range.
      ovf = sum_x[DATA_WIDTH] ^ sum_x[DATA_WIDTH-1];
    end else begin
      // Carry on add, borrow on subtract.
      ovf = sum_x[DATA_WIDTH];
    end
    result_o = sum_x[DATA_WIDTH-1:0];
    if (ovf && OVERFLOW == OVF_SAT) begin
      if (SIGN == SIGN_TWOS) begin
        result_o = sum_x[DATA_WIDTH] ? MIN_V : MAX_V;
      end else begin
        result_o = sub_i ? MIN_V : MAX_V;
      end
    end
  end

  assign ovf_o = ovf;

endmodule

// File: rtl/accum_bank.sv
// Bank of independent accumulators with a single registered output slot.
// Output handshake: a word moves when out_valid && out_ready at a rising
// edge; while out_valid && !out_ready the slot contents are held stable and
// any new signal_oe is refused and reported one cycle later on oe_drop.
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ATTR_WIDTH = 4,
  parameter int CHANNELS   = 4,
  parameter int SIGN       = 0,
  parameter int OVERFLOW   = 1,
  localparam int CH_W      = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_load,
  input  logic                  signal_init,
  input  logic                  signal_neg,
  input  logic                  signal_oe,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  output logic                  ovf_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  oe_drop
);

  // Per-channel state.
  logic [DATA_WIDTH-1:0] acc_q [CHANNELS];
  logic [DATA_WIDTH-1:0] acc_d [CHANNELS];
  logic [ATTR_WIDTH-1:0] tag_q [CHANNELS];
  logic [ATTR_WIDTH-1:0] tag_d [CHANNELS];
  logic [CHANNELS-1:0]   ovf_q;
  logic [CHANNELS-1:0]   ovf_d;

  // Output slot state.
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [ATTR_WIDTH-1:0] attr_out_q, attr_out_d;
  logic                  ovf_out_q, ovf_out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  oe_drop_q, oe_drop_d;

  // Arithmetic path for the selected channel.
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] sat_result;
  logic                  sat_ovf;
  logic                  oe_accept;

  // An init in the same cycle as a load makes the load start from zero.
  assign op_a = signal_init ? '0 : acc_q[ch_sel];

  accum_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIGN       (SIGN),
    .OVERFLOW   (OVERFLOW)
  ) u_sat (
    .a_i      (op_a),
    .b_i      (data_in),
    .sub_i    (signal_neg),
    .result_o (sat_result),
    .ovf_o    (sat_ovf)
  );

  // Next channel state: load (optionally from a cleared start) or plain init.
  always_comb begin
    acc_d = acc_q;
    tag_d = tag_q;
    ovf_d = ovf_q;
    if (signal_load) begin
      acc_d[ch_sel] = sat_result;
      tag_d[ch_sel] = attr_in;
      ovf_d[ch_sel] = sat_ovf | (ovf_q[ch_sel] & ~signal_init);
    end else if (signal_init) begin
      acc_d[ch_sel] = '0;
      tag_d[ch_sel] = '0;
      ovf_d[ch_sel] = 1'b0;
    end
  end

  // Channel registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i] <= '0;
        tag_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      acc_q <= acc_d;
      tag_q <= tag_d;
      ovf_q <= ovf_d;
    end
  end

  // The slot takes a new word when empty or being emptied this cycle.
  assign oe_accept = signal_oe && (!out_valid_q || out_ready);

  // Next output-slot state; captures pre-edge channel values.
  always_comb begin
    data_out_d  = data_out_q;
    attr_out_d  = attr_out_q;
    ovf_out_d   = ovf_out_q;
    out_valid_d = out_valid_q;
    oe_drop_d   = signal_oe && !oe_accept;
    if (oe_accept) begin
      data_out_d  = acc_q[ch_sel];
      attr_out_d  = tag_q[ch_sel];
      ovf_out_d   = ovf_q[ch_sel];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output-slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q  <= '0;
      attr_out_q  <= '0;
      ovf_out_q   <= 1'b0;
      out_valid_q <= 1'b0;
      oe_drop_q   <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      attr_out_q  <= attr_out_d;
      ovf_out_q   <= ovf_out_d;
      out_valid_q <= out_valid_d;
      oe_drop_q   <= oe_drop_d;
    end
  end

  assign data_out  = data_out_q;
  assign attr_out  = attr_out_q;
  assign ovf_out   = ovf_out_q;
  assign out_valid = out_valid_q;
  assign oe_drop   = oe_drop_q;

endmodule
